// File: rtl/ram_arbiter_2p.sv
// Two-requester arbiter for a single-port RAM: round-robin grant, latched command,
// fixed 2-cycle write and 3-cycle read sequencing with per-requester completion.
module ram_arbiter_2p #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              rw_n_a,
  input  logic              rw_n_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic              ram_rw_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

  state_t              state;
  logic                cmd_rw_n;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_din;
  logic                cmd_owner;
  logic                last_b;
  logic                can_grant;
  logic                issue_on;

  assign can_grant = (state == IDLE) && rst;
  // On a tie the requester that did not win last time takes the grant.
  assign gnt_a = can_grant && req_a && (!req_b || last_b);
  assign gnt_b = can_grant && req_b && (!req_a || !last_b);
  assign busy  = (state != IDLE);

  // Gating with rst keeps a write aborted by reset from reaching the RAM edge.
  assign issue_on = (state == ISSUE) && rst;
  assign ram_rw_n = issue_on ? cmd_rw_n : 1'b1;
  assign ram_addr = cmd_addr;
  assign ram_din  = issue_on ? cmd_din : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      last_b    <= 1'b1;
      cmd_rw_n  <= 1'b0;
      cmd_addr  <= '0;
      cmd_din   <= '0;
      cmd_owner <= 1'b0;
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_a || gnt_b) begin
            cmd_rw_n  <= gnt_b ? rw_n_b : rw_n_a;
            cmd_addr  <= gnt_b ? addr_b : addr_a;
            cmd_din   <= gnt_b ? din_b  : din_a;
            cmd_owner <= gnt_b;
            last_b    <= gnt_b;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_rw_n) begin
            state <= CAPT;
          end else begin
            state  <= IDLE;
            done_a <= !cmd_owner;
            done_b <= cmd_owner;
          end
        end
        CAPT: begin
          if (cmd_owner) rdata_b <= ram_dout;
          else           rdata_a <= ram_dout;
          done_a <= !cmd_owner;
          done_b <= cmd_owner;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
